// File: rtl/psdifir_stereo_mac.sv
// Stereo time-multiplexed N_TAPS FIR: one signed MAC, zero-cleared circular sample buffer, coefficient ROM.
// Coefficients come from the COEFS image (h[0] in the LSBs); define PSDIFIR_SAT_EN for saturating output.
`timescale 1ns/1ps
module psdifir_stereo_mac #(
  parameter int DATA_W    = 18,
  parameter int COEF_W    = 18,
  parameter int LOG2_TAPS = 6,
  parameter int ACC_W     = 48,
  parameter int OUT_SHIFT = 17,
  parameter logic [(2**LOG2_TAPS)*COEF_W-1:0] COEFS = '0
) (
  input  logic                     clockext100MHz,
  input  logic                     reset,
  input  logic                     datain_ready,
  input  logic signed [DATA_W-1:0] left_in,
  input  logic signed [DATA_W-1:0] right_in,
  output logic signed [DATA_W-1:0] left_out,
  output logic signed [DATA_W-1:0] right_out,
  output logic                     dataout_ready,
  output logic                     busy,
  output logic                     overrun
);
  localparam int N_TAPS = 2**LOG2_TAPS;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int AW     = LOG2_TAPS + 1;
  localparam int STAGES = 1;

  typedef enum logic [2:0] {CLEAR, IDLE, WRITE, MAC, FLUSH, SCALE} state_t;

  state_t                    state;
  logic [AW-1:0]             cnt;
  logic [LOG2_TAPS-1:0]      wr_ptr;
  logic [LOG2_TAPS-1:0]      k;
  logic [LOG2_TAPS-1:0]      rd_tap;
  logic signed [DATA_W-1:0]  lat_l, lat_r;
  logic signed [DATA_W-1:0]  mem [2*N_TAPS];
  logic signed [DATA_W-1:0]  rd_data;
  logic signed [COEF_W-1:0]  coef_q;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_l, acc_r;
  logic [STAGES:0]           vld_pipe, ch_pipe, clr_pipe;
  logic                      unused_acc;

  assign k         = cnt[LOG2_TAPS-1:0];
  assign rd_tap    = wr_ptr - k;
  assign busy      = (state != IDLE);
  assign prod_ext  = ACC_W'(prod);
  assign unused_acc = ^{acc_l, acc_r};

  function automatic logic signed [DATA_W-1:0] scale(input logic signed [ACC_W-1:0] a);
`ifdef PSDIFIR_SAT_EN
    logic signed [ACC_W-1:0] s;
    s = a >>> OUT_SHIFT;
    if (&s[ACC_W-1:DATA_W-1] || ~|s[ACC_W-1:DATA_W-1])
      return s[DATA_W-1:0];
    else if (s[ACC_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
`else
    return a[OUT_SHIFT+DATA_W-1:OUT_SHIFT];
`endif
  endfunction

  // Control FSM; cnt serves as clear address, tap/channel index and flush counter.
  always_ff @(posedge clockext100MHz) begin
    if (reset) begin
      state         <= CLEAR;
      cnt           <= '0;
      wr_ptr        <= '0;
      lat_l         <= '0;
      lat_r         <= '0;
      left_out      <= '0;
      right_out     <= '0;
      dataout_ready <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      dataout_ready <= 1'b0;
      overrun       <= datain_ready && (state != IDLE);
      case (state)
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= IDLE;
        end
        IDLE: if (datain_ready) begin
          lat_l <= left_in;
          lat_r <= right_in;
          state <= WRITE;
        end
        WRITE: begin
          cnt   <= '0;
          state <= MAC;
        end
        MAC: begin
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= FLUSH;
        end
        FLUSH: begin
          cnt <= cnt + 1'b1;
          if (cnt == AW'(1)) begin
            cnt   <= '0;
            state <= SCALE;
          end
        end
        SCALE: begin
          left_out      <= scale(acc_l);
          right_out     <= scale(acc_r);
          dataout_ready <= 1'b1;
          wr_ptr        <= wr_ptr + 1'b1;
          state         <= IDLE;
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Buffer layout: left channel in the lower half, right in the upper half.
  always_ff @(posedge clockext100MHz) begin
    if (state == CLEAR)
      mem[cnt] <= '0;
    else if (state == WRITE) begin
      mem[{1'b0, wr_ptr}] <= lat_l;
      mem[{1'b1, wr_ptr}] <= lat_r;
    end
  end

  // Read -> multiply -> accumulate; channel and first-tap flags ride along.
  always_ff @(posedge clockext100MHz) begin
    if (reset) vld_pipe <= '0;
    else       vld_pipe <= {vld_pipe[STAGES-1:0], state == MAC};
    ch_pipe  <= {ch_pipe[STAGES-1:0], cnt[AW-1]};
    clr_pipe <= {clr_pipe[STAGES-1:0], k == '0};
    rd_data  <= mem[{cnt[AW-1], rd_tap}];
    coef_q   <= COEFS[k*COEF_W +: COEF_W];
    prod     <= PROD_W'(rd_data) * PROD_W'(coef_q);
    if (vld_pipe[STAGES]) begin
      if (ch_pipe[STAGES]) acc_r <= (clr_pipe[STAGES] ? '0 : acc_r) + prod_ext;
      else                 acc_l <= (clr_pipe[STAGES] ? '0 : acc_l) + prod_ext;
    end
  end
endmodule
